// File: rtl/stage3_writeback.sv
// Final pipeline stage: performs a RAM write handshake, a PC redirect, or a NOP,
// then pulses pc_load to fetch. Accepts a new stage-2 result only while idle.
module stage3_writeback #(
  parameter int PC_STEP       = 4,
  parameter int WRITE_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  mblock_s3,
  input  logic [31:0] vw_value,
  input  logic [15:0] ram_address,
  input  logic        alu_is_zero,
  input  logic [15:0] pc,
  output logic        ram_w_en,
  output logic [15:0] ram_w_address,
  output logic [31:0] ram_w_value,
  input  logic        ram_ready,
  output logic        pc_load,
  output logic [15:0] pc_next,
  output logic        timeout_err
);

  // state  | meaning
  // IDLE   | waiting for a stage-2 result, in_ready=1
  // WRITE  | ram_w_en asserted, waiting for ram_ready or timeout
  // COMMIT | one-cycle pc_load pulse, then back to IDLE
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WRITE  = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  localparam logic [15:0] STEP      = 16'(PC_STEP);
  localparam logic [7:0]  TIMEOUT_L = 8'(WRITE_TIMEOUT);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        ram_w_en_q, ram_w_en_d;
  logic [15:0] ram_w_address_q, ram_w_address_d;
  logic [31:0] ram_w_value_q, ram_w_value_d;
  logic        pc_load_q, pc_load_d;
  logic [15:0] pc_next_q, pc_next_d;
  logic        timeout_err_q, timeout_err_d;

  logic [15:0] fall_through;
  logic [7:0]  cnt_inc;
  logic        take_jump;

  assign fall_through = pc + STEP;
  assign cnt_inc      = cnt_q + 8'd1;

  always_comb begin
    take_jump = 1'b0;
    case (mblock_s3)
      3'b010:  take_jump = 1'b1;
      3'b011:  take_jump = alu_is_zero;
      3'b100:  take_jump = ~alu_is_zero;
      default: take_jump = 1'b0;
    endcase
  end

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    ram_w_en_d      = ram_w_en_q;
    ram_w_address_d = ram_w_address_q;
    ram_w_value_d   = ram_w_value_q;
    pc_load_d       = 1'b0;
    pc_next_d       = pc_next_q;
    timeout_err_d   = timeout_err_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (mblock_s3 == 3'b001) begin
            state_d         = S_WRITE;
            cnt_d           = 8'd0;
            ram_w_en_d      = 1'b1;
            ram_w_address_d = ram_address;
            ram_w_value_d   = vw_value;
            // Writes always fall through; capture it now so pc need not be held.
            pc_next_d       = fall_through;
          end else begin
            state_d   = S_COMMIT;
            pc_load_d = 1'b1;
            pc_next_d = take_jump ? vw_value[15:0] : fall_through;
          end
        end
      end
      S_WRITE: begin
        if (ram_ready) begin
          state_d    = S_COMMIT;
          ram_w_en_d = 1'b0;
          pc_load_d  = 1'b1;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TIMEOUT_L) begin
            state_d       = S_COMMIT;
            ram_w_en_d    = 1'b0;
            pc_load_d     = 1'b1;
            timeout_err_d = 1'b1;
          end
        end
      end
      S_COMMIT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d    = S_IDLE;
        ram_w_en_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q         <= S_IDLE;
      cnt_q           <= 8'd0;
      ram_w_en_q      <= 1'b0;
      ram_w_address_q <= 16'd0;
      ram_w_value_q   <= 32'd0;
      pc_load_q       <= 1'b0;
      pc_next_q       <= 16'd0;
      timeout_err_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      ram_w_en_q      <= ram_w_en_d;
      ram_w_address_q <= ram_w_address_d;
      ram_w_value_q   <= ram_w_value_d;
      pc_load_q       <= pc_load_d;
      pc_next_q       <= pc_next_d;
      timeout_err_q   <= timeout_err_d;
    end
  end

  assign in_ready      = (state_q == S_IDLE);
  assign ram_w_en      = ram_w_en_q;
  assign ram_w_address = ram_w_address_q;
  assign ram_w_value   = ram_w_value_q;
  assign pc_load       = pc_load_q;
  assign pc_next       = pc_next_q;
  assign timeout_err   = timeout_err_q;

endmodule

// File: tb/tb_stage3_writeback.sv
// Bench for stage3_writeback: directed stimulus pushes expected pc_next values and
// write bursts into queues; a negedge monitor pops and compares them.
module tb_stage3_writeback;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  mblock_s3;
  logic [31:0] vw_value;
  logic [15:0] ram_address;
  logic        alu_is_zero;
  logic [15:0] pc;
  logic        ram_w_en;
  logic [15:0] ram_w_address;
  logic [31:0] ram_w_value;
  logic        ram_ready;
  logic        pc_load;
  logic [15:0] pc_next;
  logic        timeout_err;

  always #5 clk = ~clk;

  stage3_writeback #(.PC_STEP(4), .WRITE_TIMEOUT(5)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .mblock_s3(mblock_s3), .vw_value(vw_value), .ram_address(ram_address),
    .alu_is_zero(alu_is_zero), .pc(pc), .ram_w_en(ram_w_en),
    .ram_w_address(ram_w_address), .ram_w_value(ram_w_value),
    .ram_ready(ram_ready), .pc_load(pc_load), .pc_next(pc_next),
    .timeout_err(timeout_err)
  );

  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
    int          len;
  } wr_t;

  logic [15:0] exp_pc[$];
  wr_t         exp_wr[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          wr_cyc = 0;
  logic [15:0] e_pc;
  wr_t         e_wr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pc_load events against expected pc_next queue, write bursts against write queue.
  initial begin
    forever begin
      @(negedge clk);
      if (pc_load) begin
        if (exp_pc.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL pc_load_unexpected: got pc_next=%h expected no pc_load", pc_next);
        end else begin
          e_pc = exp_pc.pop_front();
          check("pc_next", 32'(pc_next), 32'(e_pc));
        end
      end
      if (ram_w_en) begin
        if (exp_wr.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL ram_w_en_unexpected: got 1 expected 0");
        end else begin
          check("ram_w_address", 32'(ram_w_address), 32'(exp_wr[0].addr));
          check("ram_w_value", ram_w_value, exp_wr[0].data);
          wr_cyc++;
        end
      end else if (wr_cyc > 0) begin
        e_wr = exp_wr.pop_front();
        check("write_len", 32'(wr_cyc), 32'(e_wr.len));
        wr_cyc = 0;
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] vw, input logic [15:0] addr,
                       input logic z, input logic [15:0] p);
    int t;
    t = 0;
    while (!in_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_wait: got in_ready=0 expected 1 within 50 cycles");
    end
    mblock_s3   = op;
    vw_value    = vw;
    ram_address = addr;
    alu_is_zero = z;
    pc          = p;
    in_valid    = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  logic [2:0]  j_op [6] = '{3'b011, 3'b011, 3'b100, 3'b100, 3'b110, 3'b010};
  logic        j_z  [6] = '{1'b1,   1'b0,   1'b0,   1'b1,   1'b0,   1'b0};
  logic [15:0] j_exp[6] = '{16'h1234, 16'h0104, 16'h1234, 16'h0104, 16'h0104, 16'h1234};

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; ram_ready = 1'b0; mblock_s3 = 3'd0;
    vw_value = 32'd0; ram_address = 16'd0; alu_is_zero = 1'b0; pc = 16'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ram_w_en", 32'(ram_w_en), 32'd0);
    check("rst_pc_load", 32'(pc_load), 32'd0);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);
    check("rst_ram_w_address", 32'(ram_w_address), 32'd0);
    check("rst_ram_w_value", ram_w_value, 32'd0);
    check("rst_pc_next", 32'(pc_next), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    reset_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("idle_in_ready", 32'(in_ready), 32'd1);
    check("idle_ram_w_en", 32'(ram_w_en), 32'd0);

    // NOP with latency checks
    exp_pc.push_back(16'h0014);
    issue(3'b000, 32'h0000_0000, 16'h0000, 1'b0, 16'h0010);
    check("nop_pc_load", 32'(pc_load), 32'd1);
    check("nop_in_ready_commit", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    check("nop_pc_load_drop", 32'(pc_load), 32'd0);
    check("nop_in_ready_back", 32'(in_ready), 32'd1);

    for (int i = 0; i < 6; i++) begin
      exp_pc.push_back(j_exp[i]);
      issue(j_op[i], 32'hABCD_1234, 16'h0000, j_z[i], 16'h0100);
    end

    // Write handshake: ready low 3 cycles then high; a competing in_valid is held off.
    ram_ready = 1'b0;
    exp_wr.push_back('{addr: 16'h0040, data: 32'hDEAD_BEEF, len: 4});
    exp_pc.push_back(16'h0204);
    issue(3'b001, 32'hDEAD_BEEF, 16'h0040, 1'b0, 16'h0200);
    mblock_s3 = 3'b000; pc = 16'h0300; in_valid = 1'b1;
    repeat (3) begin
      check("wr_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    ram_ready = 1'b1;
    check("wr_in_ready_last", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    ram_ready = 1'b0; in_valid = 1'b0;
    check("wr_commit_pc_load", 32'(pc_load), 32'd1);
    check("wr_commit_in_ready", 32'(in_ready), 32'd0);

    // ram_ready in the limit cycle is a success
    exp_wr.push_back('{addr: 16'h0050, data: 32'h0BAD_CAFE, len: 5});
    exp_pc.push_back(16'h0504);
    issue(3'b001, 32'h0BAD_CAFE, 16'h0050, 1'b0, 16'h0500);
    repeat (4) begin @(posedge clk); #1; end
    ram_ready = 1'b1;
    @(posedge clk); #1;
    ram_ready = 1'b0;
    check("limit_ready_no_err", 32'(timeout_err), 32'd0);

    // Timeout plus PC wrap
    exp_wr.push_back('{addr: 16'h0080, data: 32'h1234_5678, len: 5});
    exp_pc.push_back(16'h0000);
    issue(3'b001, 32'h1234_5678, 16'h0080, 1'b0, 16'hFFFC);
    repeat (5) begin @(posedge clk); #1; end
    check("to_ram_w_en", 32'(ram_w_en), 32'd0);
    check("to_timeout_err", 32'(timeout_err), 32'd1);
    check("to_pc_load", 32'(pc_load), 32'd1);
    exp_pc.push_back(16'h0024);
    issue(3'b000, 32'h0, 16'h0, 1'b0, 16'h0020);
    @(posedge clk); #1;
    check("to_sticky", 32'(timeout_err), 32'd1);

    // Reset in the second WRITE cycle
    exp_wr.push_back('{addr: 16'h0100, data: 32'hCAFE_F00D, len: 2});
    issue(3'b001, 32'hCAFE_F00D, 16'h0100, 1'b0, 16'h0400);
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    check("mrst_ram_w_en", 32'(ram_w_en), 32'd0);
    check("mrst_pc_load", 32'(pc_load), 32'd0);
    check("mrst_timeout_err", 32'(timeout_err), 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("mrst_in_ready", 32'(in_ready), 32'd1);
    check("mrst_timeout_err_after", 32'(timeout_err), 32'd0);

    repeat (10) @(posedge clk);
    #1;
    check("pc_queue_drained", 32'(exp_pc.size()), 32'd0);
    check("wr_queue_drained", 32'(exp_wr.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
